// File: rtl/ieee488_device_port.sv
// rtl/ieee488_device_port.sv - IEEE-488 device-side port: acceptor, source and ATN command decode
//
// Purpose:
//   Peripheral end of the PET IEEE-488 bus for one primary address. The
//   acceptor handshake receives command bytes (under ATN) and data bytes (when
//   addressed to listen); the source handshake talks host bytes onto the bus
//   when addressed to talk. Bus lines are active-low and the *_o outputs are
//   open-collector style: 1 releases the line, 0 pulls it low.
//
// Ports:
//   clk, reset, ce        system clock, sync active-high reset, 1 MHz enable
//   ieee488_*_i           sampled bus lines (active-low)
//   ieee488_*_o           bus drivers (0 = assert, 1 = release; data FF = released)
//   rx_data/rx_eoi/rx_valid/rx_ready   received byte holding register to host
//   tx_data/tx_eoi/tx_valid/tx_ready   byte from host to talk; tx_ready pulses on latch
//   listening/talking     addressed state
//   sec_addr/sec_cmd/sec_strobe        last secondary address accepted for this device
module ieee488_device_port #(
   parameter int DEV_ADDR = 8,
   parameter int SETTLE   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ce,
   input  logic [7:0] ieee488_data_i,
   input  logic       ieee488_atn_i,
   input  logic       ieee488_ifc_i,
   input  logic       ieee488_dav_i,
   input  logic       ieee488_eoi_i,
   input  logic       ieee488_nrfd_i,
   input  logic       ieee488_ndac_i,
   output logic [7:0] ieee488_data_o,
   output logic       ieee488_dav_o,
   output logic       ieee488_eoi_o,
   output logic       ieee488_nrfd_o,
   output logic       ieee488_ndac_o,
   output logic [7:0] rx_data,
   output logic       rx_eoi,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_eoi,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       listening,
   output logic       talking,
   output logic [4:0] sec_addr,
   output logic [2:0] sec_cmd,
   output logic       sec_strobe
);

   localparam logic [4:0] MY_ADDR    = 5'(DEV_ADDR);
   localparam logic [7:0] LISTEN_CMD = {3'b001, MY_ADDR};
   localparam logic [7:0] TALK_CMD   = {3'b010, MY_ADDR};
   localparam logic [7:0] UNLISTEN   = 8'h3F;
   // Settle counter runs 0..SETTLE-1; a SETTLE of 0 behaves like 1.
   localparam int         CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] SETTLE_LAST = (SETTLE > 1) ? CW'(SETTLE - 1) : '0;

   typedef enum logic [1:0] {A_IDLE, A_READY, A_ACCEPTED} acc_state_t;
   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_WAIT_RFD, S_WAIT_DAC} src_state_t;

   acc_state_t acc_state_q, acc_state_d;
   src_state_t src_state_q, src_state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic       listening_q, listening_d;
   logic       talking_q, talking_d;
   logic       armed_q, armed_d;       // our LISTEN/TALK was the last accepted byte
   logic [4:0] sec_addr_q, sec_addr_d;
   logic [2:0] sec_cmd_q, sec_cmd_d;
   logic       sec_strobe_q, sec_strobe_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_eoi_q, rx_eoi_d;
   logic       rx_valid_q, rx_valid_d;
   logic       tx_ready_q, tx_ready_d;
   logic [7:0] data_out_q, data_out_d;
   logic       dav_out_q, dav_out_d;
   logic       eoi_out_q, eoi_out_d;

   logic       bus_clear;
   logic       acc_active;
   logic       src_active;
   logic [7:0] bus_byte;
   logic       acc_nrfd;
   logic       acc_ndac;

   assign bus_clear  = reset | ~ieee488_ifc_i;
   assign acc_active = ~ieee488_atn_i | listening_q;
   assign src_active = talking_q & ieee488_atn_i;
   assign bus_byte   = ~ieee488_data_i;

   always_ff @(posedge clk) begin
      if (bus_clear) begin
         acc_state_q  <= A_IDLE;
         src_state_q  <= S_IDLE;
         cnt_q        <= '0;
         listening_q  <= 1'b0;
         talking_q    <= 1'b0;
         armed_q      <= 1'b0;
         sec_addr_q   <= '0;
         sec_cmd_q    <= '0;
         sec_strobe_q <= 1'b0;
         rx_data_q    <= '0;
         rx_eoi_q     <= 1'b0;
         rx_valid_q   <= 1'b0;
         tx_ready_q   <= 1'b0;
         data_out_q   <= 8'hFF;
         dav_out_q    <= 1'b1;
         eoi_out_q    <= 1'b1;
      end else begin
         acc_state_q  <= acc_state_d;
         src_state_q  <= src_state_d;
         cnt_q        <= cnt_d;
         listening_q  <= listening_d;
         talking_q    <= talking_d;
         armed_q      <= armed_d;
         sec_addr_q   <= sec_addr_d;
         sec_cmd_q    <= sec_cmd_d;
         sec_strobe_q <= sec_strobe_d;
         rx_data_q    <= rx_data_d;
         rx_eoi_q     <= rx_eoi_d;
         rx_valid_q   <= rx_valid_d;
         tx_ready_q   <= tx_ready_d;
         data_out_q   <= data_out_d;
         dav_out_q    <= dav_out_d;
         eoi_out_q    <= eoi_out_d;
      end
   end

   // Acceptor handshake and ATN command decode.
   always_comb begin
      acc_state_d  = acc_state_q;
      listening_d  = listening_q;
      talking_d    = talking_q;
      armed_d      = armed_q;
      sec_addr_d   = sec_addr_q;
      sec_cmd_d    = sec_cmd_q;
      sec_strobe_d = 1'b0;
      rx_data_d    = rx_data_q;
      rx_eoi_d     = rx_eoi_q;
      rx_valid_d   = rx_valid_q;
      acc_nrfd     = 1'b1;
      acc_ndac     = 1'b1;

      if (acc_active) begin
         unique case (acc_state_q)
            A_READY: begin
               acc_ndac = 1'b0;
               // Hold off the talker while the host still owns the previous data byte.
               acc_nrfd = ~(ieee488_atn_i & rx_valid_q);
            end
            A_ACCEPTED: acc_nrfd = 1'b0;
            default: ;
         endcase
      end

      if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

      if (!acc_active) begin
         acc_state_d = A_IDLE;
      end else if (ce) begin
         unique case (acc_state_q)
            A_IDLE: acc_state_d = A_READY;
            A_READY: begin
               if (!ieee488_dav_i && acc_nrfd) begin
                  acc_state_d = A_ACCEPTED;
                  armed_d     = 1'b0;
                  if (ieee488_atn_i) begin
                     rx_data_d  = bus_byte;
                     rx_eoi_d   = ~ieee488_eoi_i;
                     rx_valid_d = 1'b1;
                  end else if (bus_byte == LISTEN_CMD) begin
                     listening_d = 1'b1;
                     talking_d   = 1'b0;
                     armed_d     = 1'b1;
                  end else if (bus_byte == UNLISTEN) begin
                     listening_d = 1'b0;
                  end else if (bus_byte == TALK_CMD) begin
                     talking_d   = 1'b1;
                     listening_d = 1'b0;
                     armed_d     = 1'b1;
                  end else if (bus_byte[7:5] == 3'b010) begin
                     // TALK to another device or UNTALK
                     talking_d = 1'b0;
                  end else if (bus_byte[7:5] == 3'b011 || bus_byte[7]) begin
                     if (armed_q) begin
                        sec_addr_d   = bus_byte[4:0];
                        sec_cmd_d    = bus_byte[7:5];
                        sec_strobe_d = 1'b1;
                     end
                  end
               end
            end
            A_ACCEPTED: if (ieee488_dav_i) acc_state_d = A_READY;
            default: acc_state_d = A_IDLE;
         endcase
      end
   end

   // Source handshake. Leaving the talk-active condition drops everything at once.
   always_comb begin
      src_state_d = src_state_q;
      cnt_d       = cnt_q;
      tx_ready_d  = 1'b0;
      data_out_d  = data_out_q;
      dav_out_d   = dav_out_q;
      eoi_out_d   = eoi_out_q;

      if (!src_active) begin
         src_state_d = S_IDLE;
         data_out_d  = 8'hFF;
         dav_out_d   = 1'b1;
         eoi_out_d   = 1'b1;
      end else if (ce) begin
         unique case (src_state_q)
            S_IDLE: begin
               if (tx_valid) begin
                  data_out_d  = ~tx_data;
                  eoi_out_d   = ~tx_eoi;
                  tx_ready_d  = 1'b1;
                  cnt_d       = '0;
                  src_state_d = S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (cnt_q == SETTLE_LAST) src_state_d = S_WAIT_RFD;
               else cnt_d = cnt_q + 1'b1;
            end
            S_WAIT_RFD: begin
               // NDAC released as well means nobody is listening: keep waiting.
               if (ieee488_nrfd_i && !ieee488_ndac_i) begin
                  dav_out_d   = 1'b0;
                  src_state_d = S_WAIT_DAC;
               end
            end
            S_WAIT_DAC: begin
               if (ieee488_ndac_i) begin
                  dav_out_d   = 1'b1;
                  eoi_out_d   = 1'b1;
                  data_out_d  = 8'hFF;
                  src_state_d = S_IDLE;
               end
            end
            default: src_state_d = S_IDLE;
         endcase
      end
   end

   assign ieee488_data_o = data_out_q;
   assign ieee488_dav_o  = dav_out_q;
   assign ieee488_eoi_o  = eoi_out_q;
   assign ieee488_nrfd_o = acc_nrfd;
   assign ieee488_ndac_o = acc_ndac;
   assign rx_data        = rx_data_q;
   assign rx_eoi         = rx_eoi_q;
   assign rx_valid       = rx_valid_q;
   assign tx_ready       = tx_ready_q;
   assign listening      = listening_q;
   assign talking        = talking_q;
   assign sec_addr       = sec_addr_q;
   assign sec_cmd        = sec_cmd_q;
   assign sec_strobe     = sec_strobe_q;

endmodule
